// File: rtl/ltpi_pkg.sv
// Shared LTPI constants: I2C event codes, event field width and channel count.
package ltpi_pkg;

    localparam int unsigned I2C_EVT_W     = 4;
    localparam int unsigned MAX_SMBUS_DEV = 6;
    localparam int unsigned LVL_OUT_W     = 5;

    typedef logic [I2C_EVT_W-1:0] i2c_evt_t;

    // Event codes produced by the SMBus relay/echo path.
    localparam i2c_evt_t I2C_EVT_IDLE  = 4'h0;
    localparam i2c_evt_t I2C_EVT_START = 4'h1;
    localparam i2c_evt_t I2C_EVT_STOP  = 4'h2;
    localparam i2c_evt_t I2C_EVT_DATA0 = 4'h3;
    localparam i2c_evt_t I2C_EVT_DATA1 = 4'h4;
    localparam i2c_evt_t I2C_EVT_ACK   = 4'h5;
    localparam i2c_evt_t I2C_EVT_NACK  = 4'h6;

endpackage

// File: rtl/i2c_evt_fifo.sv
// Single-clock event FIFO for one I2C channel. Pointers wrap modulo FIFO_DEPTH,
// occupancy is kept in a separate counter. Flush has priority over push/pop.
module i2c_evt_fifo
    import ltpi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  i2c_evt_t         din,
    output i2c_evt_t         dout,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    i2c_evt_t         mem_q [FIFO_DEPTH];
    i2c_evt_t         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state: a pop on a full FIFO frees the slot the same-cycle push uses.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Storage, pointer and level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= I2C_EVT_IDLE;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/mgmt_i2c_event_tx.sv
// Packs per-channel I2C event codes into the I2C event field of each outgoing
// LTPI operational frame. Each active channel queues events in its own FIFO;
// a frame load pops one entry per channel into a registered field.
module mgmt_i2c_event_tx
    import ltpi_pkg::*;
#(
    parameter int unsigned NUM_OF_SMBUS_DEV = 6,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter logic [3:0]  EVT_IDLE         = I2C_EVT_IDLE
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [MAX_SMBUS_DEV-1:0][I2C_EVT_W-1:0] evt_in,
    input  logic [MAX_SMBUS_DEV-1:0]                evt_in_vld,
    input  logic                                    frm_load,
    output logic [MAX_SMBUS_DEV-1:0][I2C_EVT_W-1:0] frm_i2c_evt,
    output logic                                    frm_i2c_evt_vld,
    input  logic [MAX_SMBUS_DEV-1:0]                soft_i2c_channel_rst,
    input  logic                                    link_operational,
    output logic [MAX_SMBUS_DEV-1:0][LVL_OUT_W-1:0] fifo_level,
    output logic [MAX_SMBUS_DEV-1:0]                ovf_sticky,
    output logic [MAX_SMBUS_DEV-1:0][7:0]           drop_cnt
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [MAX_SMBUS_DEV-1:0] ch_flush;
    logic [MAX_SMBUS_DEV-1:0] fifo_push;
    logic [MAX_SMBUS_DEV-1:0] fifo_pop;
    i2c_evt_t                 fifo_dout  [MAX_SMBUS_DEV];
    logic                     fifo_full  [MAX_SMBUS_DEV];
    logic                     fifo_empty [MAX_SMBUS_DEV];

    logic [MAX_SMBUS_DEV-1:0][I2C_EVT_W-1:0] frm_evt_q, frm_evt_d;
    logic                                    frm_vld_q, frm_vld_d;
    logic [MAX_SMBUS_DEV-1:0]                ovf_q, ovf_d;
    logic [MAX_SMBUS_DEV-1:0][7:0]           drop_q, drop_d;

    // Per-channel flush/push/pop qualification; IDLE strobes are not events.
    always_comb begin
        ch_flush  = '0;
        fifo_push = '0;
        fifo_pop  = '0;
        for (int unsigned i = 0; i < MAX_SMBUS_DEV; i++) begin
            ch_flush[i]  = soft_i2c_channel_rst[i] | ~link_operational;
            fifo_push[i] = evt_in_vld[i] & (evt_in[i] != EVT_IDLE) & ~ch_flush[i];
            fifo_pop[i]  = frm_load & ~ch_flush[i];
        end
    end

    genvar g;
    for (g = 0; g < MAX_SMBUS_DEV; g++) begin : g_ch
        if (g < NUM_OF_SMBUS_DEV) begin : g_fifo
            logic [LVL_W-1:0] lvl;
            i2c_evt_fifo #(
                .FIFO_DEPTH (FIFO_DEPTH),
                .LVL_W      (LVL_W)
            ) u_fifo (
                .clk     (clk),
                .reset_n (reset_n),
                .flush   (ch_flush[g]),
                .push    (fifo_push[g]),
                .pop     (fifo_pop[g]),
                .din     (evt_in[g]),
                .dout    (fifo_dout[g]),
                .level   (lvl),
                .full    (fifo_full[g]),
                .empty   (fifo_empty[g])
            );
            assign fifo_level[g] = LVL_OUT_W'(lvl);
        end else begin : g_tie
            // Unused channel: behaves as a permanently empty FIFO.
            assign fifo_dout[g]  = EVT_IDLE;
            assign fifo_full[g]  = 1'b0;
            assign fifo_empty[g] = 1'b1;
            assign fifo_level[g] = '0;
        end
    end

    // Frame field: on load, take each head (or IDLE when empty or flushing).
    always_comb begin
        frm_evt_d = frm_evt_q;
        frm_vld_d = frm_load;
        if (frm_load) begin
            for (int unsigned i = 0; i < MAX_SMBUS_DEV; i++) begin
                frm_evt_d[i] = (ch_flush[i] | fifo_empty[i]) ? EVT_IDLE : fifo_dout[i];
            end
        end
    end

    // Overflow: push to a full FIFO without a same-cycle pop is dropped.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        for (int unsigned i = 0; i < MAX_SMBUS_DEV; i++) begin
            if (i < NUM_OF_SMBUS_DEV) begin
                if (ch_flush[i]) begin
                    ovf_d[i]  = 1'b0;
                    drop_d[i] = '0;
                end else if (fifo_push[i] & fifo_full[i] & ~fifo_pop[i]) begin
                    ovf_d[i] = 1'b1;
                    if (drop_q[i] != 8'hFF) begin
                        drop_d[i] = drop_q[i] + 8'd1;
                    end
                end
            end
        end
    end

    // Frame field register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frm_evt_q <= {MAX_SMBUS_DEV{EVT_IDLE}};
            frm_vld_q <= 1'b0;
        end else begin
            frm_evt_q <= frm_evt_d;
            frm_vld_q <= frm_vld_d;
        end
    end

    // Overflow and drop status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q  <= '0;
            drop_q <= '0;
        end else begin
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign frm_i2c_evt     = frm_evt_q;
    assign frm_i2c_evt_vld = frm_vld_q;
    assign ovf_sticky      = ovf_q;
    assign drop_cnt        = drop_q;

endmodule
